// File: rtl/mux_sel_seq.sv
// Channel scanner driving the s1/s2 selects of a 4:1 mux, with per-channel dwell and a sample strobe.
// Define MUX_SEL_SEQ_SKIP_MASK_EN to honour en_mask; otherwise all four channels are always scanned.
module mux_sel_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       single,
    input  logic [3:0] en_mask,
    input  logic [7:0] dwell,
    output logic       s1,
    output logic       s2,
    output logic [1:0] ch_idx,
    output logic       sample,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ch, ch_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       single_q, single_nxt;
    logic       stop_pend, stop_pend_nxt;
    logic       done_q, done_nxt;
    logic       err_q, err_nxt;

    logic [3:0] eff_mask;
    logic [7:0] dwell_eff;
    logic [1:0] first_ch;
    logic [1:0] adv_ch;
    logic       adv_any;
    logic       adv_wrap;
    logic       end_scan;

`ifdef MUX_SEL_SEQ_SKIP_MASK_EN
    assign eff_mask = en_mask;
`else
    assign eff_mask = en_mask | 4'b1111;
`endif

    assign dwell_eff = (dwell == 8'd0) ? 8'd1 : dwell;

    // Search order ch+1, ch+2, ch+3, ch; descending loop lets the nearest match win.
    function automatic logic [2:0] next_enabled(input logic [3:0] m, input logic [1:0] c);
        logic [2:0] r;
        logic [1:0] idx;
        r = {1'b0, c};
        for (int unsigned k = 4; k > 0; k--) begin
            idx = c + 2'(k);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        first_ch = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (eff_mask[i-1]) first_ch = 2'(i - 1);
        end
    end

    assign {adv_any, adv_ch} = next_enabled(eff_mask, ch);
    assign adv_wrap          = (adv_ch <= ch);

    assign sample   = (state == DWELL) && (cnt == 8'd1);
    assign end_scan = stop_pend || stop || !adv_any || (single_q && adv_wrap);

    always_comb begin
        state_nxt     = state;
        ch_nxt        = ch;
        cnt_nxt       = cnt;
        single_nxt    = single_q;
        stop_pend_nxt = stop_pend;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (|eff_mask) begin
                        state_nxt     = DWELL;
                        ch_nxt        = first_ch;
                        cnt_nxt       = dwell_eff;
                        single_nxt    = single;
                        stop_pend_nxt = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DWELL: begin
                stop_pend_nxt = stop_pend | stop;
                if (sample) begin
                    if (end_scan) begin
                        state_nxt     = IDLE;
                        ch_nxt        = '0;
                        cnt_nxt       = '0;
                        single_nxt    = 1'b0;
                        stop_pend_nxt = 1'b0;
                        done_nxt      = 1'b1;
                    end else begin
                        ch_nxt  = adv_ch;
                        cnt_nxt = dwell_eff;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ch_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            cnt       <= '0;
            single_q  <= 1'b0;
            stop_pend <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            cnt       <= cnt_nxt;
            single_q  <= single_nxt;
            stop_pend <= stop_pend_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    assign s1     = ch[1];
    assign s2     = ch[0];
    assign ch_idx = ch;
    assign busy   = (state == DWELL);
    assign done   = done_q;
`ifdef MUX_SEL_SEQ_SKIP_MASK_EN
    assign err    = err_q;
`else
    assign err    = 1'b0 & err_q;
`endif

endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed bench for mux_sel_seq: expected per-cycle outputs queued up front, checked one per clock.
module tb_mux_sel_seq;

    logic       clk = 1'b0;
    logic       rst, start, stop, single;
    logic [3:0] en_mask;
    logic [7:0] dwell;
    logic       s1, s2, sample, busy, done, err;
    logic [1:0] ch_idx;

    mux_sel_seq dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .single(single),
        .en_mask(en_mask), .dwell(dwell),
        .s1(s1), .s2(s2), .ch_idx(ch_idx), .sample(sample),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] v;   // {s1, s2, ch_idx, sample, busy, done, err}
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [1:0]  seq2 [6];
    logic [1:0]  seq7 [3];

    task automatic push(input string tag, input logic [1:0] c, input logic smp,
                        input logic b, input logic d, input logic e);
        exp_t x;
        x.tag = tag;
        x.v   = {c[1], c[0], c, smp, b, d, e};
        sb.push_back(x);
    endtask

    task automatic push_chan(input string tag, input logic [1:0] c, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) push(tag, c, (i == n - 1), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_idle(input string tag, input logic d, input logic e);
        push(tag, 2'b00, 1'b0, 1'b0, d, e);
    endtask

    task automatic tick();
        exp_t       x;
        logic [7:0] obs;
        @(posedge clk);
        #1;
        obs = {s1, s2, ch_idx, sample, busy, done, err};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty got=%b want=none", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.v) else begin
                bad++;
                $error("FAIL %s got=%b want=%b", x.tag, obs, x.v);
            end
        end
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
`ifdef MUX_SEL_SEQ_SKIP_MASK_EN
        seq2 = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        seq7 = '{2'd2, 2'd2, 2'd2};
`else
        seq2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        seq7 = '{2'd0, 2'd1, 2'd2};
`endif
        rst = 1'b1; start = 1'b0; stop = 1'b0; single = 1'b0;
        en_mask = 4'hF; dwell = 8'd3;

        push_idle("reset", 1'b0, 1'b0);
        push_idle("reset", 1'b0, 1'b0);
        ticks(2);
        rst = 1'b0;
        push_idle("idle_quiet", 1'b0, 1'b0);
        tick();

        // Full single pass, dwell 3; start and single toggled mid-scan must be ignored
        dwell = 8'd3; en_mask = 4'hF; single = 1'b1; start = 1'b1;
        for (int unsigned c = 0; c < 4; c++) push_chan("scan4", 2'(c), 3);
        push_idle("scan4_done", 1'b1, 1'b0);
        push_idle("scan4_after", 1'b0, 1'b0);
        tick(); start = 1'b0;
        ticks(3);
        start = 1'b1; single = 1'b0;
        tick(); start = 1'b0; single = 1'b1;
        ticks(9);

        // dwell 0 treated as 1, continuous, stop during a sample cycle
        dwell = 8'd0; en_mask = 4'b0101; single = 1'b0; start = 1'b1;
        for (int unsigned i = 0; i < 6; i++) push_chan("dwell0", seq2[i], 1);
        push_idle("dwell0_stop", 1'b1, 1'b0);
        push_idle("dwell0_after", 1'b0, 1'b0);
        tick(); start = 1'b0;
        ticks(5);
        stop = 1'b1;
        tick(); stop = 1'b0;
        tick();

        // Stop on cycle 2 of channel 1; dwell changed mid-channel must not matter
        dwell = 8'd5; en_mask = 4'hF; single = 1'b0; start = 1'b1;
        push_chan("stop_ch0", 2'd0, 5);
        push_chan("stop_ch1", 2'd1, 5);
        push_idle("stop_done", 1'b1, 1'b0);
        push_idle("stop_after", 1'b0, 1'b0);
        tick(); start = 1'b0;
        ticks(5);
        tick();
        stop = 1'b1; dwell = 8'd9;
        tick(); stop = 1'b0;
        ticks(4);
        dwell = 8'd3;

        // Empty mask
        en_mask = 4'b0000; dwell = 8'd1; single = 1'b1; start = 1'b1;
`ifdef MUX_SEL_SEQ_SKIP_MASK_EN
        push_idle("mask0_err", 1'b0, 1'b1);
        push_idle("mask0_after", 1'b0, 1'b0);
        tick(); start = 1'b0;
        tick();
`else
        for (int unsigned c = 0; c < 4; c++) push_chan("mask0_scan", 2'(c), 1);
        push_idle("mask0_done", 1'b1, 1'b0);
        push_idle("mask0_after", 1'b0, 1'b0);
        tick(); start = 1'b0;
        ticks(5);
`endif

        // Reset mid-dwell on channel 2 aborts without done
        dwell = 8'd4; en_mask = 4'hF; single = 1'b0; start = 1'b1;
        push_chan("rst_ch0", 2'd0, 4);
        push_chan("rst_ch1", 2'd1, 4);
        push("rst_ch2", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        push("rst_ch2", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        push_idle("rst_abort", 1'b0, 1'b0);
        push_idle("rst_after", 1'b0, 1'b0);
        tick(); start = 1'b0;
        ticks(9);
        rst = 1'b1;
        tick(); rst = 1'b0;
        tick();

        // start and stop together in IDLE: stop wins, no err
        start = 1'b1; stop = 1'b1; en_mask = 4'hF;
        push_idle("start_stop", 1'b0, 1'b0);
        push_idle("start_stop", 1'b0, 1'b0);
        tick(); start = 1'b0; stop = 1'b0;
        tick();

        // Mask narrowed to 1000 during channel 0
        dwell = 8'd3; en_mask = 4'hF; single = 1'b1; start = 1'b1;
        push_chan("mask_chg_ch0", 2'd0, 3);
`ifdef MUX_SEL_SEQ_SKIP_MASK_EN
        push_chan("mask_chg", 2'd3, 3);
`else
        for (int unsigned c = 1; c < 4; c++) push_chan("mask_chg", 2'(c), 3);
`endif
        push_idle("mask_chg_done", 1'b1, 1'b0);
        push_idle("mask_chg_after", 1'b0, 1'b0);
        tick(); start = 1'b0; en_mask = 4'b1000;
`ifdef MUX_SEL_SEQ_SKIP_MASK_EN
        ticks(7);
`else
        ticks(13);
`endif

        // Single-channel mask re-enters; stop held pending from a non-sample cycle
        dwell = 8'd2; en_mask = 4'b0100; single = 1'b0; start = 1'b1;
        for (int unsigned i = 0; i < 3; i++) push_chan("one_ch", seq7[i], 2);
        push_idle("one_ch_done", 1'b1, 1'b0);
        push_idle("one_ch_after", 1'b0, 1'b0);
        tick(); start = 1'b0;
        ticks(4);
        stop = 1'b1;
        tick(); stop = 1'b0;
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_seq.md
MUX_SEL_SEQ -- requirements
Module: mux_sel_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  level; begins a scan when sampled high in IDLE.
REQ-005 stop  input  1  level; requests scan termination.
REQ-006 single  input  1  1 = one pass over enabled channels; 0 = continuous; sampled with start.
REQ-007 en_mask  input  4  per-channel enable; bit0 = a, bit1 = b, bit2 = c, bit3 = d.
REQ-008 dwell  input  8  cycles per channel; value 0 SHALL be treated as 1.
REQ-009 s1  output  1  select MSB, driving the 4:1 mux s1; 0 = a/b pair, 1 = c/d pair.
REQ-010 s2  output  1  select LSB, driving the 4:1 mux s2; 0 = a or c, 1 = b or d.
REQ-011 ch_idx  output  2  current channel, equal to {s1,s2}.
REQ-012 sample  output  1  one-cycle strobe in the last dwell cycle of a channel; mux output y is settled.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse on return to IDLE after a scan.
REQ-015 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 States: IDLE, DWELL. No other states.
REQ-017 IDLE: s1 = s2 = 0, busy = 0, sample = 0.
REQ-018 IDLE, start = 1, stop = 0, effective mask nonzero -> DWELL on the lowest enabled channel; dwell counter = max(dwell,1); single latched.
REQ-019 start at edge N -> busy = 1 and s1/s2 valid from cycle N+1.
REQ-020 IDLE, start = 1, effective mask zero -> stay IDLE; err = 1 for one cycle.
REQ-021 IDLE, start = 1 and stop = 1 in the same cycle -> stop wins; stay IDLE, no err.
REQ-022 DWELL: counter decrements each cycle; sample = 1 when counter = 1; each channel SHALL last exactly max(dwell,1) cycles.
REQ-023 dwell is sampled on channel entry; changing it mid-dwell SHALL NOT affect the current channel.
REQ-024 Advance: the next channel is the next higher enabled index, wrapping 3 -> 0, computed from en_mask as sampled in the sample cycle.
REQ-025 A single-enabled-channel mask SHALL re-enter the same channel and re-issue sample every max(dwell,1) cycles.
REQ-026 single = 1: after the sample of the highest enabled channel (no wrap), go to IDLE and pulse done.
REQ-027 stop sampled high in any DWELL cycle SHALL be held pending; at the end of the current dwell (sample still issued) -> IDLE and pulse done.
REQ-028 Effective mask zero at advance -> IDLE and pulse done.
REQ-029 The done pulse SHALL coincide with the first IDLE cycle; s1/s2 return to 0 in that same cycle.
REQ-030 start is ignored while busy.

Reset
REQ-031 rst high at an edge -> IDLE; s1 = s2 = 0, ch_idx = 0, sample = busy = done = err = 0; pending stop cleared; counter cleared.
REQ-032 rst mid-scan SHALL abort without a done pulse; rst takes priority over all inputs.

Configuration
REQ-033 Macro MUX_SEL_SEQ_SKIP_MASK_EN defined: en_mask is honoured as above.
REQ-034 Macro not defined: en_mask is ignored; the effective mask is 4'b1111; err is tied to 0.

Verification
REQ-035 dwell = 3, en_mask = 1111, single = 1, start pulse -> {s1,s2} = 00,01,10,11 for 3 cycles each; sample on cycles 3,6,9,12; done at cycle 13.
REQ-036 dwell = 0, en_mask = 0101, single = 0 -> channels 0,2,0,2..., one cycle each; sample every cycle.
REQ-037 dwell = 5, continuous, stop asserted on cycle 2 of channel 1 -> channel 1 completes (sample at its 5th cycle), then IDLE with done.
REQ-038 en_mask = 0000, start (macro defined) -> err pulse, busy stays 0; macro undefined -> full scan.
REQ-039 rst asserted mid-dwell on channel 2 -> next cycle s1 = s2 = 0, busy = 0, no done.
REQ-040 start = stop = 1 in IDLE -> no state change; mask changed from 1111 to 1000 during channel 0 -> next channel 3.
